// File: rtl/fsm_counter_cmd_seq.sv
// rtl/fsm_counter_cmd_seq.sv - command FIFO and launch/wait sequencer for the FSM counter stage
module fsm_counter_cmd_seq #(
    parameter int DEPTH       = 4,
    parameter int AW          = 2,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_cmd_valid,
    input  logic [6:0]    i_cmd_num,
    output logic          o_cmd_ready,
    output logic          o_zero_drop,
    output logic          o_run,
    output logic [6:0]    o_num_cnt,
    input  logic          i_idle,
    input  logic          i_done,
    output logic [AW:0]   o_level,
    output logic          o_busy,
    output logic [7:0]    o_done_cnt,
    output logic          o_err,
    input  logic          i_err_clr
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

    state_e          state_q, state_d;
    logic [6:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     level_q, level_d;
    logic [7:0]      timer_q, timer_d;
    logic [7:0]      done_cnt_q, done_cnt_d;
    logic            err_q, err_d;
    logic            zero_drop_q;
    logic            full, pop, push, push_wr, timeout;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign pop     = (state_q == S_ISSUE);
    // The pop is known from registered state, so a full FIFO still accepts on the issuing edge.
    assign o_cmd_ready = !full || pop;
    assign push    = i_cmd_valid && o_cmd_ready;
    assign push_wr = push && (i_cmd_num != 7'd0);
    assign timeout = (state_q == S_WAIT) && !i_done && (timer_q == 8'(TIMEOUT_CYC - 1));

    always_comb begin
        level_d = level_q;
        case ({push_wr, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        done_cnt_d = done_cnt_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (level_q != '0 && i_idle && !err_q) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                timer_d = 8'd0;
            end
            S_WAIT: begin
                timer_d = timer_q + 8'd1;
                if (i_done) begin
                    done_cnt_d = done_cnt_q + 8'd1;
                    state_d    = S_IDLE;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (i_err_clr)    err_d = 1'b0;
        else if (timeout) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            timer_q     <= 8'd0;
            done_cnt_q  <= 8'd0;
            err_q       <= 1'b0;
            zero_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            timer_q     <= timer_d;
            done_cnt_q  <= done_cnt_d;
            err_q       <= err_d;
            zero_drop_q <= push && (i_cmd_num == 7'd0);
            if (push_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_wr) mem_q[wr_ptr_q] <= i_cmd_num;
    end

    assign o_run       = (state_q == S_ISSUE);
    assign o_num_cnt   = o_run ? mem_q[rd_ptr_q] : 7'd0;
    assign o_level     = level_q;
    assign o_busy      = (state_q != S_IDLE) || (level_q != '0);
    assign o_done_cnt  = done_cnt_q;
    assign o_err       = err_q;
    assign o_zero_drop = zero_drop_q;

endmodule

// File: tb/tb_fsm_counter_cmd_seq.sv
// tb/tb_fsm_counter_cmd_seq.sv - self-checking bench for fsm_counter_cmd_seq
module tb_fsm_counter_cmd_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_cmd_valid;
    logic [6:0] i_cmd_num;
    logic       o_cmd_ready, o_zero_drop, o_run;
    logic [6:0] o_num_cnt;
    logic       i_idle, i_done;
    logic [2:0] o_level;
    logic       o_busy;
    logic [7:0] o_done_cnt;
    logic       o_err;
    logic       i_err_clr;

    always #5 clk = ~clk;

    fsm_counter_cmd_seq #(.DEPTH(4), .AW(2), .TIMEOUT_CYC(200)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_cmd_valid(i_cmd_valid), .i_cmd_num(i_cmd_num),
        .o_cmd_ready(o_cmd_ready), .o_zero_drop(o_zero_drop),
        .o_run(o_run), .o_num_cnt(o_num_cnt),
        .i_idle(i_idle), .i_done(i_done),
        .o_level(o_level), .o_busy(o_busy), .o_done_cnt(o_done_cnt),
        .o_err(o_err), .i_err_clr(i_err_clr)
    );

    // Counter stage model: counts o_num_cnt cycles after a launch, then pulses done.
    logic       hold_busy, suppress_done, running, done_r;
    logic [6:0] rem;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running <= 1'b0;
            rem     <= 7'd0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (o_run) begin
                running <= 1'b1;
                rem     <= o_num_cnt;
            end else if (running) begin
                if (rem <= 7'd1) begin
                    running <= 1'b0;
                    done_r  <= !suppress_done;
                end else begin
                    rem <= rem - 7'd1;
                end
            end
        end
    end
    assign i_idle = !running && !hold_busy;
    assign i_done = done_r;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int run_count = 0;
    int last_run_cyc = 0;
    logic [6:0] sb[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset_n && o_run) begin
            run_count++;
            last_run_cyc = cyc;
            if (sb.size() == 0) begin
                check("run_unexpected", 32'(o_num_cnt), 32'hFFFF);
            end else begin
                check("run_num", 32'(o_num_cnt), 32'(sb.pop_front()));
            end
        end
    end

    typedef struct {
        logic       valid;
        logic [6:0] num;
        logic       acc;
        logic [2:0] lvl;
        logic       rdy;
        logic       zd;
    } vec_t;
    vec_t tbl[7];

    task automatic do_reset();
        reset_n = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_num = 7'd0;
        i_err_clr = 1'b0;
        hold_busy = 1'b0;
        suppress_done = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic push(input logic [6:0] n);
        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd_num = n;
        if (n != 7'd0) sb.push_back(n);
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (o_done_cnt != 8'(n) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(o_done_cnt), 32'(n));
    endtask

    task automatic wait_run(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_run) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit seen;
        int rc0, k;

        tbl[0] = '{1'b1, 7'd0, 1'b1, 3'd0, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 7'd1, 1'b1, 3'd1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 7'd2, 1'b1, 3'd2, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 7'd3, 1'b1, 3'd3, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 7'd4, 1'b1, 3'd4, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 7'd5, 1'b0, 3'd4, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 7'd0, 1'b0, 3'd4, 1'b0, 1'b0};

        // Reset state and a single job
        do_reset();
        check("rst_ready", 32'(o_cmd_ready), 1);
        check("rst_level", 32'(o_level), 0);
        check("rst_run", 32'(o_run), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done_cnt", 32'(o_done_cnt), 0);
        check("rst_err", 32'(o_err), 0);
        check("rst_zero_drop", 32'(o_zero_drop), 0);
        push(7'd3);
        check("t1_level", 32'(o_level), 1);
        wait_done(1, 50, "t1_done_cnt");
        check("t1_busy", 32'(o_busy), 0);

        // Zero drop and fill to full while the counter is held busy
        do_reset();
        rc0 = run_count;
        hold_busy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            i_cmd_valid = tbl[i].valid;
            i_cmd_num = tbl[i].num;
            if (tbl[i].acc && tbl[i].num != 7'd0) sb.push_back(tbl[i].num);
            @(posedge clk);
            #1;
            i_cmd_valid = 1'b0;
            check($sformatf("t2_level_%0d", i), 32'(o_level), 32'(tbl[i].lvl));
            check($sformatf("t2_ready_%0d", i), 32'(o_cmd_ready), 32'(tbl[i].rdy));
            check($sformatf("t2_zdrop_%0d", i), 32'(o_zero_drop), 32'(tbl[i].zd));
        end
        check("t2_no_run_held", 32'(run_count - rc0), 0);
        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd_num = 7'd5;
        hold_busy = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_cmd_ready) begin
                sb.push_back(7'd5);
                seen = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
        end
        i_cmd_valid = 1'b0;
        check("t2_fifth_accepted", 32'(seen), 1);
        wait_done(5, 200, "t2_done_cnt");
        check("t2_sb_empty", 32'(sb.size()), 0);
        check("t2_busy", 32'(o_busy), 0);

        // Watchdog timeout, launch blocking, error clear and clear priority
        do_reset();
        rc0 = run_count;
        suppress_done = 1'b1;
        push(7'd10);
        push(7'd7);
        k = 0;
        while (!o_err && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("t4_err_set", 32'(o_err), 1);
        check("t4_wait_cycles", 32'(cyc - last_run_cyc), 201);
        repeat (10) @(negedge clk);
        check("t4_runs_blocked", 32'(run_count - rc0), 1);
        check("t4_level_held", 32'(o_level), 1);
        check("t4_err_sticky", 32'(o_err), 1);
        suppress_done = 1'b0;
        i_err_clr = 1'b1;
        @(posedge clk);
        #1;
        i_err_clr = 1'b0;
        check("t4_err_cleared", 32'(o_err), 0);
        wait_done(1, 50, "t4_done_after_clr");
        suppress_done = 1'b1;
        i_err_clr = 1'b1;
        push(7'd2);
        k = 0;
        while (o_busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("t4_clr_idle", 32'(o_busy), 0);
        check("t4_clr_wins", 32'(o_err), 0);
        check("t4_done_unchanged", 32'(o_done_cnt), 1);
        i_err_clr = 1'b0;
        suppress_done = 1'b0;

        // Push and pop on the same edge with a full FIFO
        do_reset();
        hold_busy = 1'b1;
        push(7'd11);
        push(7'd12);
        push(7'd13);
        push(7'd14);
        check("t5_full_level", 32'(o_level), 4);
        hold_busy = 1'b0;
        wait_run(20, seen);
        check("t5_issue_seen", 32'(seen), 1);
        check("t5_issue_level", 32'(o_level), 4);
        check("t5_issue_ready", 32'(o_cmd_ready), 1);
        i_cmd_valid = 1'b1;
        i_cmd_num = 7'd15;
        sb.push_back(7'd15);
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
        check("t5_level_kept", 32'(o_level), 4);
        wait_done(5, 300, "t5_done_cnt");
        check("t5_sb_empty", 32'(sb.size()), 0);

        // Asynchronous reset in the middle of a job
        do_reset();
        hold_busy = 1'b1;
        push(7'd100);
        push(7'd20);
        push(7'd30);
        push(7'd40);
        hold_busy = 1'b0;
        wait_run(20, seen);
        repeat (5) @(negedge clk);
        check("t6_pre_level", 32'(o_level), 3);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_level", 32'(o_level), 0);
        check("t6_run", 32'(o_run), 0);
        check("t6_done_cnt", 32'(o_done_cnt), 0);
        check("t6_ready", 32'(o_cmd_ready), 1);
        check("t6_busy", 32'(o_busy), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        push(7'd2);
        wait_done(1, 50, "t6_recover");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
